// File: rtl/tlb_pkg.sv
// tlb_pkg: TLB sizes, packed entry layout, op/state encodings and pack/unpack/match helpers
package tlb_pkg;
  localparam int TLB_ENTRIES = 32;
  localparam int TLB_IDX_W = $clog2(TLB_ENTRIES);
  localparam int TLB_ENTRY_W = 94;
  localparam int LO1_LSB = 0;
  localparam int LO0_LSB = 25;
  localparam int G_BIT = 50;
  localparam int ASID_LSB = 51;
  localparam int VPN2_LSB = 59;
  localparam int MASK_LSB = 78;
  typedef enum logic [1:0] {OP_NONE, OP_TLBR, OP_TLBWI, OP_TLBWR} tlb_op_t;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_PROBE} tlb_seq_state_t;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
    logic [31:0] pm;
  } tlb_regs_t;
  function automatic logic [TLB_ENTRY_W-1:0] tlb_pack(input logic [15:0] mask, input logic [18:0] vpn2,
                                                      input logic [7:0] asid, input logic [25:0] lo0,
                                                      input logic [25:0] lo1);
    logic [TLB_ENTRY_W-1:0] e;
    e = '0;
    e[MASK_LSB +: 16] = mask;
    e[VPN2_LSB +: 19] = vpn2;
    e[ASID_LSB +: 8] = asid;
    e[G_BIT] = lo0[0] & lo1[0];
    e[LO0_LSB +: 25] = lo0[25:1];
    e[LO1_LSB +: 25] = lo1[25:1];
    return e;
  endfunction
  // G is stored once and replicated into bit 0 of both EntryLo registers
  function automatic tlb_regs_t tlb_unpack(input logic [TLB_ENTRY_W-1:0] e);
    tlb_regs_t r;
    r.hi = {e[VPN2_LSB +: 19], 5'b0, e[ASID_LSB +: 8]};
    r.lo0 = {6'b0, e[LO0_LSB +: 25], e[G_BIT]};
    r.lo1 = {6'b0, e[LO1_LSB +: 25], e[G_BIT]};
    r.pm = {3'b0, e[MASK_LSB +: 16], 13'b0};
    return r;
  endfunction
  function automatic logic tlb_match(input logic [15:0] e_mask, input logic [18:0] e_vpn2,
                                     input logic [7:0] e_asid, input logic e_g,
                                     input logic [18:0] vpn2, input logic [7:0] asid);
    return (((e_vpn2 ^ vpn2) & ~{3'b0, e_mask}) == '0) && (e_g || e_asid == asid);
  endfunction
endpackage

// File: rtl/tlb_random.sv
// tlb_random: CP0 Random counter, counting down from the top entry and wrapping at Wired
module tlb_random
  import tlb_pkg::*;
#(
  parameter int IDX_W = TLB_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic [IDX_W-1:0] wired,
  input  logic             wiredWrite,
  output logic [IDX_W-1:0] random
);
  localparam logic [IDX_W-1:0] TOP = '1;
  logic [IDX_W-1:0] random_d;
  assign random_d = (wiredWrite || (advance && random == wired)) ? TOP : advance ? random - 1'b1 : random;
  always_ff @(posedge clk) begin
    random <= rst ? TOP : random_d;
  end
endmodule

// File: rtl/tlb_sequencer.sv
// tlb_sequencer: sequences TLBR/TLBWI/TLBWR/TLBP against the TLB entry RAM and owns Random
module tlb_sequencer
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int ENTRY_W = TLB_ENTRY_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  tlbOp,
  input  logic                        tlbProbe,
  input  logic [31:0]                 regIndexIn,
  input  logic [31:0]                 regEntryHiIn,
  input  logic [31:0]                 regEntryLo0In,
  input  logic [31:0]                 regEntryLo1In,
  input  logic [31:0]                 regPageMaskIn,
  input  logic [$clog2(ENTRIES)-1:0]  regWiredIn,
  input  logic                        regWiredWrite,
  output logic                        stall,
  output logic [$clog2(ENTRIES)-1:0]  regRandomOut,
  output logic                        rdDone,
  output logic [31:0]                 rdEntryHi,
  output logic [31:0]                 rdEntryLo0,
  output logic [31:0]                 rdEntryLo1,
  output logic [31:0]                 rdPageMask,
  output logic                        probeDone,
  output logic [31:0]                 probeIndex,
  output logic [$clog2(ENTRIES)-1:0]  tlbAddr,
  output logic                        tlbRe,
  output logic                        tlbWe,
  output logic [ENTRY_W-1:0]          tlbWdata,
  input  logic [ENTRY_W-1:0]          tlbRdata,
  output logic                        uTlbFlush
);
  localparam int IDX_W = $clog2(ENTRIES);
  tlb_seq_state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic flush_q;
  logic [31:0] probe_q;
  tlb_regs_t rd_q, rd_now;
  logic [TLB_ENTRY_W-1:0] rdata;
  logic idle, probing, hit, busy, unused_bits;
  assign rdata = TLB_ENTRY_W'(tlbRdata);
  assign idle = ~rst & (state_q == S_IDLE);
  assign probing = ~rst & (state_q == S_PROBE);
  // ptr_q is the entry whose read data is arriving this cycle; the next entry is addressed alongside
  assign hit = probing & tlb_match(rdata[MASK_LSB +: 16], rdata[VPN2_LSB +: 19], rdata[ASID_LSB +: 8],
                                   rdata[G_BIT], regEntryHiIn[31:13], regEntryHiIn[7:0]);
  assign probeDone = hit | (probing & (ptr_q == IDX_W'(ENTRIES - 1)));
  assign rdDone = ~rst & (state_q == S_READ);
  assign busy = (idle & (tlbProbe | (tlbOp == OP_TLBR))) | (probing & ~probeDone);
  assign stall = busy;
  assign tlbRe = busy;
  assign tlbWe = idle & tlbOp[1];
  assign tlbAddr = probing ? ptr_q + 1'b1 : tlbProbe ? '0 : (tlbOp == OP_TLBWR) ? regRandomOut : regIndexIn[IDX_W-1:0];
  assign tlbWdata = ENTRY_W'(tlb_pack(regPageMaskIn[28:13], regEntryHiIn[31:13], regEntryHiIn[7:0],
                                      regEntryLo0In[25:0], regEntryLo1In[25:0]));
  assign rd_now = tlb_unpack(rdata);
  assign {rdEntryHi, rdEntryLo0, rdEntryLo1, rdPageMask} = rdDone ? rd_now : rd_q;
  assign probeIndex = probeDone ? {~hit, 31'(hit ? ptr_q : '0)} : probe_q;
  assign uTlbFlush = flush_q;
  assign state_d = idle ? (tlbProbe ? S_PROBE : (tlbOp == OP_TLBR) ? S_READ : S_IDLE)
                 : (probing & ~probeDone) ? S_PROBE : S_IDLE;
  assign unused_bits = ^{regIndexIn[31:IDX_W], regEntryHiIn[12:8], regEntryLo0In[31:26],
                         regEntryLo1In[31:26], regPageMaskIn[31:29], regPageMaskIn[12:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      flush_q <= 1'b0;
      rd_q <= '0;
      probe_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= probing ? ptr_q + 1'b1 : '0;
      flush_q <= tlbWe;
      if (rdDone) rd_q <= rd_now;
      if (probeDone) probe_q <= probeIndex;
    end
  end
  tlb_random #(.IDX_W(IDX_W)) u_random (
    .clk       (clk),
    .rst       (rst),
    .advance   (~stall),
    .wired     (regWiredIn),
    .wiredWrite(regWiredWrite),
    .random    (regRandomOut)
  );
endmodule

// File: tb/tb_tlb_sequencer.sv
// tb_tlb_sequencer: directed and randomized TLB op sequences checked against a field-level TLB model
module tb_tlb_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] tlbOp = 2'b00;
  logic tlbProbe = 1'b0;
  logic [31:0] regIndexIn = '0, regEntryHiIn = '0, regEntryLo0In = '0, regEntryLo1In = '0, regPageMaskIn = '0;
  logic [4:0] regWiredIn = '0;
  logic regWiredWrite = 1'b0;
  logic stall, rdDone, probeDone, tlbRe, tlbWe, uTlbFlush;
  logic [4:0] regRandomOut, tlbAddr;
  logic [31:0] rdEntryHi, rdEntryLo0, rdEntryLo1, rdPageMask, probeIndex;
  logic [93:0] tlbWdata, tlbRdata;
  logic [93:0] ram [32];
  logic [18:0] m_vpn2 [32];
  logic [15:0] m_mask [32];
  logic [7:0] m_asid [32];
  logic [24:0] m_lo0 [32];
  logic [24:0] m_lo1 [32];
  logic m_g [32];
  logic [4:0] m_rand = 5'd31;
  logic m_flush = 1'b0;
  int n_pass = 0, n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  tlb_sequencer dut (
    .clk(clk), .rst(rst), .tlbOp(tlbOp), .tlbProbe(tlbProbe), .regIndexIn(regIndexIn),
    .regEntryHiIn(regEntryHiIn), .regEntryLo0In(regEntryLo0In), .regEntryLo1In(regEntryLo1In),
    .regPageMaskIn(regPageMaskIn), .regWiredIn(regWiredIn), .regWiredWrite(regWiredWrite),
    .stall(stall), .regRandomOut(regRandomOut), .rdDone(rdDone), .rdEntryHi(rdEntryHi),
    .rdEntryLo0(rdEntryLo0), .rdEntryLo1(rdEntryLo1), .rdPageMask(rdPageMask),
    .probeDone(probeDone), .probeIndex(probeIndex), .tlbAddr(tlbAddr), .tlbRe(tlbRe),
    .tlbWe(tlbWe), .tlbWdata(tlbWdata), .tlbRdata(tlbRdata), .uTlbFlush(uTlbFlush)
  );

  // entry RAM with one-cycle read latency
  always @(posedge clk) begin
    if (tlbWe) ram[tlbAddr] <= tlbWdata;
    if (tlbRe) tlbRdata <= ram[tlbAddr];
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input int e, input logic [31:0] hi);
    return (((m_vpn2[e] ^ hi[31:13]) & ~{3'b0, m_mask[e]}) == 19'h0) && (m_g[e] || m_asid[e] == hi[7:0]);
  endfunction

  task automatic look(input bit es, input bit erd, input bit epd);
    @(negedge clk);
    chk("stall", stall, es);
    chk("random", regRandomOut, m_rand);
    chk("uTlbFlush", uTlbFlush, m_flush);
    chk("rdDone", rdDone, erd);
    chk("probeDone", probeDone, epd);
  endtask

  task automatic adv(input bit es);
    logic [4:0] a;
    @(posedge clk);
    m_flush = !rst && tlbOp[1];
    if (!rst && tlbOp[1]) begin
      a = (tlbOp == 2'b11) ? m_rand : regIndexIn[4:0];
      m_mask[a] = regPageMaskIn[28:13];
      m_vpn2[a] = regEntryHiIn[31:13];
      m_asid[a] = regEntryHiIn[7:0];
      m_g[a] = regEntryLo0In[0] & regEntryLo1In[0];
      m_lo0[a] = regEntryLo0In[25:1];
      m_lo1[a] = regEntryLo1In[25:1];
    end
    if (rst || regWiredWrite) m_rand = 5'd31;
    else if (!es) m_rand = (m_rand == regWiredIn) ? 5'd31 : m_rand - 5'd1;
    #1;
    tlbOp = 2'b00;
    tlbProbe = 1'b0;
    regWiredWrite = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      look(0, 0, 0);
      adv(0);
    end
  endtask

  task automatic set_wired(input logic [4:0] w);
    regWiredIn = w;
    regWiredWrite = 1'b1;
    look(0, 0, 0);
    adv(0);
  endtask

  task automatic wr(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] hi,
                    input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] pm);
    logic [4:0] a;
    regIndexIn = {27'h0, idx};
    regEntryHiIn = hi;
    regEntryLo0In = lo0;
    regEntryLo1In = lo1;
    regPageMaskIn = pm;
    tlbOp = op;
    a = (op == 2'b11) ? m_rand : idx;
    look(0, 0, 0);
    chk("tlbWe", tlbWe, 1);
    chk("wr_addr", tlbAddr, a);
    chk("wr_data", tlbWdata, {pm[28:13], hi[31:13], hi[7:0], lo0[0] & lo1[0], lo0[25:1], lo1[25:1]});
    adv(0);
    look(0, 0, 0);
    chk("tlbWe_off", tlbWe, 0);
    adv(0);
  endtask

  task automatic rd(input logic [4:0] idx);
    logic [31:0] ehi;
    regIndexIn = {27'h0, idx};
    tlbOp = 2'b01;
    ehi = {m_vpn2[idx], 5'b0, m_asid[idx]};
    look(1, 0, 0);
    chk("rd_re", tlbRe, 1);
    chk("rd_addr", tlbAddr, idx);
    adv(1);
    look(0, 1, 0);
    chk("rdEntryHi", rdEntryHi, ehi);
    chk("rdEntryLo0", rdEntryLo0, {6'b0, m_lo0[idx], m_g[idx]});
    chk("rdEntryLo1", rdEntryLo1, {6'b0, m_lo1[idx], m_g[idx]});
    chk("rdPageMask", rdPageMask, {3'b0, m_mask[idx], 13'b0});
    adv(0);
    look(0, 0, 0);
    chk("rdEntryHi_hold", rdEntryHi, ehi);
    adv(0);
  endtask

  task automatic probe(input logic [31:0] hi);
    int k;
    logic [31:0] eidx;
    k = 32;
    for (int e = 31; e >= 0; e--) if (m_hit(e, hi)) k = e;
    eidx = (k == 32) ? 32'h8000_0000 : 32'(k);
    regEntryHiIn = hi;
    tlbProbe = 1'b1;
    look(1, 0, 0);
    chk("probe_addr0", tlbAddr, 0);
    adv(1);
    for (int c = 1; c <= ((k == 32) ? 31 : k); c++) begin
      look(1, 0, 0);
      adv(1);
    end
    look(0, 0, 1);
    chk("probeIndex", probeIndex, eidx);
    adv(0);
    look(0, 0, 0);
    chk("probeIndex_hold", probeIndex, eidx);
    adv(0);
  endtask

  initial begin
    int j;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    look(0, 0, 0);
    chk("rst_tlbWe", tlbWe, 0);
    chk("rst_probeIndex", probeIndex, 0);
    chk("rst_rdEntryHi", rdEntryHi, 0);
    adv(0);
    idle_cycles(3);
    set_wired(5'd4);
    idle_cycles(62);
    set_wired(5'd31);
    idle_cycles(5);
    set_wired(5'd4);
    for (int i = 0; i < 32; i++) begin
      if (i == 5) wr(2'b10, 5'd5, 32'h0040_2005, 32'h1, 32'h1, 32'h0);
      else wr(2'b10, 5'(i), {1'b1, 18'($urandom), 13'($urandom)}, $urandom, $urandom, $urandom);
    end
    for (int w = 0; w < 40 && m_rand != 5'd17; w++) begin
      look(0, 0, 0);
      adv(0);
    end
    wr(2'b11, 5'd0, 32'h0040_2005, 32'h0000_1007, 32'h0000_1047, 32'h0);
    rd(5'd17);
    rd(5'd5);
    for (int i = 0; i < 6; i++) rd(5'($urandom_range(0, 31)));
    probe(32'h0040_2099);
    probe(32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      j = $urandom_range(0, 31);
      probe({m_vpn2[j], 5'b0, m_asid[j] ^ ((i == 3) ? 8'h5a : 8'h00)});
    end
    regEntryHiIn = 32'h0;
    tlbProbe = 1'b1;
    look(1, 0, 0);
    adv(1);
    for (int c = 1; c < 10; c++) begin
      look(1, 0, 0);
      adv(1);
    end
    rst = 1'b1;
    look(0, 0, 0);
    adv(0);
    rst = 1'b0;
    look(0, 0, 0);
    chk("rst_mid_tlbRe", tlbRe, 0);
    chk("rst_mid_probeIndex", probeIndex, 0);
    chk("rst_mid_random", regRandomOut, 31);
    adv(0);
    idle_cycles(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
